// File: rtl/prime_pkg.sv
// prime_pkg: shared definitions for the next-prime scheduler slice.
//   PRIME_W      operand/result width of the next-prime engine
//   DEF_*        default requester count, watchdog limit and counter width
//   state_t      scheduler FSM states
//   rr_next()    wrap-around successor of a requester index
//
// Engine handshake: the scheduler holds eng_operand stable and pulses
// eng_start for one cycle. The engine later pulses eng_done for one cycle
// with eng_result valid in that same cycle. A new eng_start always restarts
// the engine, so an abandoned (timed-out) job needs no abort signal.
package prime_pkg;

  localparam int PRIME_W     = 7;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 2048;
  localparam int DEF_TW      = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Index following idx among n requesters, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req      request vector, one bit per requester
//   ptr      highest-priority index; search runs ptr, ptr+1, ... with wrap
//   gnt      one-hot grant (all zero when no request)
//   gnt_idx  encoded index of the granted requester (0 when none)
//   any_gnt  at least one request present
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any_gnt
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s -= NREQ;
    return IW'(s);
  endfunction

  logic [IW-1:0] idx;

  // First hit in the rotated search order wins; later hits are masked by any_gnt.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_idx(ptr, k);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prime_req_scheduler.sv
// prime_req_scheduler: shares one next-prime engine among NREQ requesters.
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/operand     per-requester request, operand i at [i*W +: W]
//   req_ready             one-hot accept, only in IDLE
//   rsp_valid/data/err    registered one-cycle response to the job owner;
//                         err=1 means the engine timed out and data=0
//   eng_start/operand     one-cycle start pulse, operand held ISSUE..WAIT
//   eng_done/result       engine completion strobe and result
//   busy                  scheduler not in IDLE
module prime_req_scheduler
  import prime_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = PRIME_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = DEF_TW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_operand,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_operand,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              busy
);

  localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, owner_q, gnt_idx;
  logic [NREQ-1:0]        gnt, owner_oh;
  logic                   any_gnt, tmo;
  logic [TW-1:0]          cnt_q;
  logic [NREQ-1:0][W-1:0] ops;

  assign ops      = req_operand;
  assign owner_oh = NREQ'(1) << owner_q;
  assign tmo      = (cnt_q == CNT_LAST);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Grant is held off while reset is asserted so every output reads 0 then.
  assign req_ready = (state_q == IDLE && rst) ? gnt : '0;
  assign eng_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_done || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      eng_operand <= '0;
      cnt_q       <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: if (any_gnt) begin
          eng_operand <= ops[gnt_idx];
          owner_q     <= gnt_idx;
          ptr_q       <= IW'(rr_next(32'(gnt_idx), NREQ));
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          // eng_done takes priority over a watchdog expiry in the same cycle.
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_oh;
          end else if (tmo) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_oh;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prime_req_scheduler.md
Name: prime_req_scheduler

Overview:
- Shares one next-prime search engine among NREQ requesters.
- Arbitrates requests round-robin, issues the operand to the engine with a one-cycle start pulse, waits for completion, and returns the result to the owning requester.
- The engine returns the smallest prime ≥ operand; operand ≤ 2 yields 2.
- A watchdog converts a hung engine into an error response so requesters never stall.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 7, operand/result width.
- TIMEOUT, 2048, max WAIT cycles before error; must be ≥ 2.
- TW, 12, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_operand  in  NREQ*W  packed operands; requester i at [i*W +: W].
- req_ready  out  NREQ  one-hot grant/accept.
- rsp_valid  out  NREQ  one-cycle response pulse, one-hot.
- rsp_data  out  W  result for the pulsing requester.
- rsp_err  out  1  qualifies rsp_valid; 1 = engine timeout, rsp_data=0.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_operand  out  W  operand to engine; held stable from ISSUE through WAIT.
- eng_done  in  1  engine completion strobe.
- eng_result  in  W  engine result; valid while eng_done=1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE.
  - RR pointer=0.
  - All outputs 0; eng_operand=0.
  - Timeout counter=0; owner register=0.
  - An in-flight job is discarded and no response is ever generated for it.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid=1, searching from the RR pointer upward with wrap NREQ-1→0.
  - req_ready is all-zero if no req_valid is set.
  - On the edge where req_valid&req_ready: latch operand into eng_operand, latch owner index, set RR pointer=(owner+1) mod NREQ, go to ISSUE.
- ISSUE (1 cycle):
  - eng_start=1; clear timeout counter; go to WAIT.
  - eng_done in this cycle is ignored.
- WAIT:
  - If eng_done=1: capture eng_result, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: result=0, rsp_err=1, go to RESP.
  - Else counter+1.
  - If eng_done and timeout coincide, eng_done wins (no error).
- RESP (1 cycle): rsp_valid[owner]=1, rsp_data and rsp_err registered; go to IDLE.
- req_ready is 0 in ISSUE/WAIT/RESP. Requesters must hold req_valid and operand until accepted.
- Latency: accept edge → eng_start next cycle. eng_done in cycle k → rsp_valid in cycle k+1. A new grant is possible the cycle after RESP.
- Minimum turnaround per job: ISSUE + 1 WAIT + RESP + IDLE = 4 cycles.
- Fairness: a continuously requesting requester is served at most once per NREQ grants when all NREQ requesters are requesting.
- Responses on rsp_valid/rsp_data/rsp_err are registered (glitch-free).
- Operand 0, 1 and 2 are passed unmodified; the engine owns that corner case.
- A stale eng_done while IDLE is ignored.
- After a timeout, the next eng_start reloads the engine; no separate abort is required.

Decomposition:
- Shared package prime_pkg:
  - PRIME_W=7.
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - Default NREQ and TIMEOUT constants.
  - The engine handshake description (start/done).
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational; reused by other shared-resource controllers.

Test Plan:
- Single request: requester 0, operand 24; engine model done after 10 cycles with 29 → rsp_valid=0001, rsp_data=29, rsp_err=0; eng_start exactly one pulse, one cycle after accept.
- Corner operands: operands 0, 2, 127 sent serially from requester 1 → responses 2, 2, 127 on rsp_valid=0010; busy low between jobs.
- Round-robin: all four requesters valid continuously with operands 8, 14, 20, 90 → grant order 0,1,2,3,0; responses 11, 17, 23, 97 routed to matching rsp_valid bits.
- Timeout: engine never asserts eng_done → rsp_valid for owner exactly TIMEOUT cycles after entering WAIT, rsp_err=1, rsp_data=0; next request completes normally.
- Coincidence: eng_done asserted on the cycle counter==TIMEOUT-1 → rsp_err=0, engine result returned.
- Async reset mid-WAIT: rst low for 3 cycles, including off-edge assertion → outputs 0 immediately, no response for the aborted job, RR pointer back to 0; the first post-reset grant goes to requester 0.
